// File: rtl/systolic_mv_nxn_pkg.sv
// systolic_pkg: shared types and fixed-point helpers for the systolic
// matrix-vector unit.
//   data_t        signed data word at the default width
//   wide_t        wide signed scratch type for accumulator post-processing
//   latency()     accept-to-out_valid latency for an N x N array
//   q_shift()     arithmetic right shift by the fractional bits, optional
//                 round-half-up bias added first
//   sat_to_width() clamp to the signed range of a given width
package systolic_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  typedef logic signed [DEF_WIDTH-1:0] data_t;

  // Large enough for ACC_W at N=16, WIDTH=32.
  localparam int unsigned WIDE_W = 72;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int unsigned latency(input int unsigned n);
    return n + 2;
  endfunction

  function automatic wide_t q_shift(input wide_t v, input int unsigned frac,
                                    input bit rnd);
    wide_t t;
    t = v;
    if (rnd && frac > 0) t = t + (wide_t'(1) <<< (frac - 1));
    return t >>> frac;
  endfunction

  function automatic wide_t sat_to_width(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_mv_nxn_if.sv
// systolic_mv_nxn_if: control, weight-load and stream signals of the
// systolic matrix-vector unit.
//   clr          sync flush of in-flight vectors
//   w_we/w_row/w_data  weight row write
//   in_valid/in_ready/x_in    x vector stream (element j at [j*WIDTH +: WIDTH])
//   out_valid/out_ready/y_out y vector stream (element i at [i*WIDTH +: WIDTH])
//   busy         any vector in flight or held at the output
// master = producer/consumer side, slave = the unit.
interface systolic_mv_nxn_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned RW = $clog2(N);

  logic               clr;
  logic               w_we;
  logic [RW-1:0]      w_row;
  logic [N*WIDTH-1:0] w_data;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] x_in;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] y_out;
  logic               busy;

  modport master (
    output clr, w_we, w_row, w_data, in_valid, x_in, out_ready,
    input  in_ready, out_valid, y_out, busy
  );

  modport slave (
    input  clr, w_we, w_row, w_data, in_valid, x_in, out_ready,
    output in_ready, out_valid, y_out, busy
  );
endinterface

// File: rtl/systolic_mv_nxn_pe.sv
// systolic_pe: registered multiply-accumulate cell.
//   clk, rst_n  clock, synchronous active-low reset
//   en          shared stall enable
//   w_ld, w_in  load the stationary weight (independent of en)
//   x_in        input element for this column
//   psum_in     partial sum from the left neighbour
//   psum_out    psum_in + x_in*w, registered
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    w_ld,
  input  logic [WIDTH-1:0]        w_in,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [ACC_W-1:0] psum_in,
  output logic signed [ACC_W-1:0] psum_out
);
  logic signed [WIDTH-1:0]   w_q;
  logic signed [2*WIDTH-1:0] prod;

  assign prod = (2*WIDTH)'(x_in) * (2*WIDTH)'(w_q);

  always_ff @(posedge clk) begin
    if (!rst_n)    w_q <= '0;
    else if (w_ld) w_q <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  psum_out <= '0;
    else if (en) psum_out <= psum_in + ACC_W'(prod);
  end
endmodule

// File: rtl/systolic_mv_nxn.sv
// systolic_mv_nxn: N x N weight-stationary systolic matrix-vector unit,
// y = W*x in signed fixed point with FRAC_BIT fractional bits.
//   clk, rst_n  clock, synchronous active-low reset (clears weights too)
//   bus         systolic_mv_nxn_if.slave: clr, weight write, x/y streams, busy
// Latency N+2 from accept edge to out_valid; one vector per cycle unstalled.
// Optional: define SYSTOLIC_ROUND_EN for round-half-up before the shift,
// otherwise the shift truncates toward -inf.
module systolic_mv_nxn
  import systolic_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC_BIT = 10
) (
  input logic              clk,
  input logic              rst_n,
  systolic_mv_nxn_if.slave bus
);
  localparam int unsigned ACC_W   = 2*WIDTH + $clog2(N);
  localparam int unsigned RW      = $clog2(N);
  localparam int unsigned LATENCY = latency(N);
`ifdef SYSTOLIC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                    en;
  // vld[0] skew, vld[1..N] PE columns, vld[N+1] de-skew, vld[N+2] output
  logic [LATENCY:0]        vld;
  logic [N*WIDTH-1:0]      y_q;
  logic [N*WIDTH-1:0]      y_nxt;
  logic signed [WIDTH-1:0] col_x [N];
  logic signed [ACC_W-1:0] ps    [N][N];
  logic signed [ACC_W-1:0] dsk   [N];

  assign en            = !(vld[LATENCY] && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = vld[LATENCY];
  assign bus.y_out     = y_q;
  assign bus.busy      = |vld;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) vld <= '0;
    else if (en)           vld <= {vld[LATENCY-1:0], bus.in_valid};
  end

  // Column j is delayed j extra cycles so it meets the psum wavefront at
  // PE column j; x is shared by all rows of a column.
  for (genvar j = 0; j < N; j++) begin : g_skew
    logic signed [WIDTH-1:0] sr [j+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k <= j; k++) sr[k] <= '0;
      end else if (en) begin
        sr[0] <= bus.x_in[j*WIDTH +: WIDTH];
        for (int unsigned k = 1; k <= j; k++) sr[k] <= sr[k-1];
      end
    end
    assign col_x[j] = sr[j];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    logic w_ld;
    assign w_ld = bus.w_we && (bus.w_row == RW'(i));
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [ACC_W-1:0] pin;
      if (j == 0) begin : g_first
        assign pin = '0;
      end else begin : g_next
        assign pin = ps[i][j-1];
      end
      systolic_pe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .w_ld     (w_ld),
        .w_in     (bus.w_data[j*WIDTH +: WIDTH]),
        .x_in     (col_x[j]),
        .psum_in  (pin),
        .psum_out (ps[i][j])
      );
    end
  end

  // Every row finishes on the same edge; this stage realigns the row sums
  // into one vector before fixed-point post-processing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) dsk[i] <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < N; i++) dsk[i] <= ps[i][N-1];
    end
  end

  always_comb begin
    wide_t r;
    r     = '0;
    y_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      r = sat_to_width(q_shift(wide_t'(dsk[i]), FRAC_BIT, ROUND), WIDTH);
      y_nxt[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
  end

  // Only a valid result replaces y_out, so clr and idle cycles leave it held.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   y_q <= '0;
    else if (en && !bus.clr && vld[LATENCY-1])    y_q <= y_nxt;
  end
endmodule

// File: tb/tb_systolic_mv_nxn.sv
// Bench for systolic_mv_nxn at N=3, WIDTH=16, FRAC_BIT=10. Expected y vectors
// come from an integer reference model over the bench's own weight copy.
module tb_systolic_mv_nxn;
  import systolic_pkg::*;

  localparam int unsigned N    = 3;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned FRAC = 10;
  localparam int unsigned LAT  = N + 2;
  localparam int unsigned VW   = N * WIDTH;
`ifdef SYSTOLIC_ROUND_EN
  localparam logic [15:0] RND_POS = 16'h0001;
  localparam logic [15:0] RND_NEG = 16'h0000;
`else
  localparam logic [15:0] RND_POS = 16'h0000;
  localparam logic [15:0] RND_NEG = 16'hFFFF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  systolic_mv_nxn_if #(.N(N), .WIDTH(WIDTH)) bus ();

  systolic_mv_nxn #(.N(N), .WIDTH(WIDTH), .FRAC_BIT(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;
  int unsigned  cyc = 0;
  int unsigned  n_stall = 0;
  data_t        wm [N][N];
  logic [VW-1:0] expq [$];
  int unsigned  out_cyc [$];
  logic         prev_stall = 1'b0;
  logic [VW-1:0] prev_y = '0;
  logic [VW-1:0] last_y = '0;
  logic         acc_flag = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // y_i = sat(floor((sum_j W[i][j]*x[j] [+ half]) / 2^FRAC))
  function automatic logic [VW-1:0] model(input logic [VW-1:0] x);
    logic [VW-1:0] y;
    longint s;
    data_t xe;
    y = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s = 0;
      for (int unsigned j = 0; j < N; j++) begin
        xe = x[j*WIDTH +: WIDTH];
        s += longint'(wm[i][j]) * longint'(xe);
      end
`ifdef SYSTOLIC_ROUND_EN
      s += longint'(1) << (FRAC - 1);
`endif
      s = s >>> FRAC;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      y[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
    return y;
  endfunction

  function automatic logic [VW-1:0] pack3(input data_t a0, input data_t a1,
                                          input data_t a2);
    return {a2, a1, a0};
  endfunction

  function automatic data_t rand_elem();
    if ($urandom_range(0, 3) == 0) return data_t'($urandom);
    return data_t'(int'($urandom_range(0, 4095)) - 2048);
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return pack3(rand_elem(), rand_elem(), rand_elem());
  endfunction

  task automatic wr_row(input int unsigned row, input logic [VW-1:0] d);
    bus.w_we   = 1'b1;
    bus.w_row  = 2'(row);
    bus.w_data = d;
    @(posedge clk); #1;
    bus.w_we = 1'b0;
    if (row < N)
      for (int unsigned j = 0; j < N; j++) wm[row][j] = d[j*WIDTH +: WIDTH];
  endtask

  // One clock: observe at negedge, score, then advance past the posedge.
  task automatic cycle();
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_y", bus.y_out, prev_y);
    end
    if (bus.out_valid && !bus.out_ready) begin
      check("stall_in_ready", bus.in_ready, 0);
      n_stall++;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) check("spurious_out", bus.out_valid, 0);
      else check("y", bus.y_out, expq.pop_front());
      out_cyc.push_back(cyc);
      last_y = bus.y_out;
    end
    prev_stall = bus.out_valid && !bus.out_ready && !bus.clr;
    prev_y     = bus.y_out;
    acc_flag   = bus.in_valid && bus.in_ready && !bus.clr;
    if (bus.clr) expq.delete();
    else if (acc_flag) expq.push_back(model(bus.x_in));
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input logic [VW-1:0] x);
    int unsigned n;
    n = 0;
    bus.x_in = x;
    bus.in_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 50);
    bus.in_valid = 1'b0;
    if (!acc_flag) check("send_accept", acc_flag, 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((bus.busy || expq.size() != 0) && n < 100) begin
      cycle();
      n++;
    end
    check("drain_busy", bus.busy, 0);
    check("drain_queue", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_y", bus.y_out, 0);
    rst_n = 1'b1;
    expq.delete();
    prev_stall = 1'b0;
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++) wm[i][j] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned n;
    logic [VW-1:0] y_before;
    bus.clr = 1'b0; bus.w_we = 1'b0; bus.w_row = '0; bus.w_data = '0;
    bus.in_valid = 1'b0; bus.x_in = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_in_ready", bus.in_ready, 1);

    // Single vector: latency and value
    wr_row(0, pack3(16'h0400, 16'h0800, 0));
    wr_row(1, pack3(16'h0C00, 16'h1000, 0));
    bus.x_in = pack3(16'h0400, 16'h0C00, 0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_latency", n, LAT);
    check("t1_y", bus.y_out, pack3(16'h1C00, 16'h3C00, 0));
    @(posedge clk); #1;
    check("t1_out_done", bus.out_valid, 0);
    check("t1_busy", bus.busy, 0);

    // Back-to-back
    out_cyc.delete();
    send(pack3(16'h0400, 16'h0C00, 0));
    send(pack3(16'h0800, 16'h1000, 0));
    drain();
    check("t2_count", out_cyc.size(), 2);
    if (out_cyc.size() == 2) check("t2_consecutive", out_cyc[1] - out_cyc[0], 1);
    check("t2_y1", last_y, pack3(16'h2800, 16'h5800, 0));

    // Five-cycle stall mid-stream
    n_stall = 0;
    for (int c = 0; c < 16; c++) begin
      if (!bus.in_valid || acc_flag) begin
        bus.in_valid = 1'b1;
        bus.x_in = rand_vec();
      end
      bus.out_ready = !(c >= 7 && c < 12);
      cycle();
    end
    bus.in_valid = 1'b0;
    drain();
    check("t3_stall_cycles", n_stall, 5);

    // Saturation
    wr_row(0, pack3(16'h1000, 16'h1000, 0));
    send(pack3(16'h2000, 16'h2000, 0));
    drain();
    check("t4_pos_sat", last_y[15:0], 16'h7FFF);
    wr_row(0, pack3(16'hF000, 16'hF000, 0));
    send(pack3(16'h2000, 16'h2000, 0));
    drain();
    check("t4_neg_sat", last_y[15:0], 16'h8000);

    // Rounding / truncation at exactly one half LSB
    wr_row(0, pack3(16'h0001, 0, 0));
    send(pack3(16'h0200, 0, 0));
    drain();
    check("t5_half_pos", last_y[15:0], RND_POS);
    send(pack3(16'hFE00, 0, 0));
    drain();
    check("t5_half_neg", last_y[15:0], RND_NEG);

    // Random weights (plus an ignored out-of-range row) and random traffic
    for (int unsigned r = 0; r < 4; r++) wr_row(r, rand_vec());
    for (int c = 0; c < 150; c++) begin
      if (!bus.in_valid || acc_flag) begin
        bus.in_valid = ($urandom_range(0, 4) != 0);
        bus.x_in = rand_vec();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    drain();

    // clr with three vectors in flight, competing input dropped
    wr_row(0, pack3(16'h0400, 16'h0800, 0));
    wr_row(1, pack3(16'h0C00, 16'h1000, 0));
    wr_row(2, pack3(0, 0, 0));
    for (int k = 0; k < 3; k++) send(rand_vec());
    y_before = bus.y_out;
    bus.clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in = rand_vec();
    cycle();
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_clr_valid", bus.out_valid, 0);
    check("t6_clr_busy", bus.busy, 0);
    check("t6_clr_y_held", bus.y_out, y_before);
    send(pack3(16'h0400, 16'h0C00, 0));
    drain();
    check("t6_after_clr_y", last_y, pack3(16'h1C00, 16'h3C00, 0));

    // Reset mid-stream zeroes weights
    send(rand_vec());
    send(rand_vec());
    do_reset();
    send(pack3(16'h0400, 16'h0C00, 0));
    drain();
    check("t6_after_rst_y", last_y, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
